// File: rtl/cmam_pkg.sv
// Shared types and constants for the cmam register-bus arbiter.
package cmam_pkg;

  localparam int CMAM_AW = 7;
  localparam int CMAM_DW = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } cmam_state_e;

  typedef struct packed {
    logic               we;
    logic [CMAM_AW-1:0] addr;
    logic [CMAM_DW-1:0] wdata;
  } cmam_req_t;

  // Counter preload for a read latency; out-of-range values are clamped to 1..7.
  function automatic logic [2:0] cmam_lat_load(input int rd_lat);
    if (rd_lat < 1) begin
      return 3'd0;
    end else if (rd_lat > 7) begin
      return 3'd6;
    end else begin
      return 3'(rd_lat - 1);
    end
  endfunction

endpackage

// File: rtl/cmam_rr_pick.sv
// Combinational two-way round-robin picker: on contention the port not granted last wins.
module cmam_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt,
  output logic       sel
);

  // Grant decode from the request pair and the last-grant pointer.
  always_comb begin
    gnt = 2'b00;
    sel = 1'b0;
    case (req)
      2'b01: begin
        gnt = 2'b01;
        sel = 1'b0;
      end
      2'b10: begin
        gnt = 2'b10;
        sel = 1'b1;
      end
      2'b11: begin
        if (last) begin
          gnt = 2'b01;
          sel = 1'b0;
        end else begin
          gnt = 2'b10;
          sel = 1'b1;
        end
      end
      default: begin
        gnt = 2'b00;
        sel = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/cmam_reg_arb.sv
// Two-port round-robin arbiter and sequencer for the cmam register bus.
// Optional feature: define CMAM_ARB_WRPROT_EN to reject port-1 writes at or above PROT_BASE.
module cmam_reg_arb
  import cmam_pkg::*;
#(
  parameter int            AW        = CMAM_AW,
  parameter int            DW        = CMAM_DW,
  parameter int            RD_LAT    = 2,
  parameter logic [AW-1:0] PROT_BASE = 7'h60
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  output logic [DW-1:0] rdata0,
  output logic          err0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata1,
  output logic          err1,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] data_wr,
  output logic          wren,
  output logic          rden,
  input  logic [DW-1:0] data_rd,
  output logic          busy
);

`ifdef CMAM_ARB_WRPROT_EN
  localparam logic WRPROT_EN = 1'b1;
`else
  localparam logic WRPROT_EN = 1'b0;
`endif

  localparam logic [2:0]    LAT_LOAD = cmam_lat_load(RD_LAT);
  localparam logic [DW-1:0] ZERO_DW  = {DW{1'b0}};

  cmam_state_e   state_r;
  cmam_state_e   state_nxt_s;
  cmam_req_t     req_r;
  cmam_req_t     win_s;
  logic [1:0]    req_s;
  logic [1:0]    gnt_s;
  logic          sel_s;
  logic          grant_s;
  logic          prot_s;
  logic          port_r;
  logic          last_r;
  logic [2:0]    cnt_r;
  logic          wren_r;
  logic          rden_r;
  logic          ack0_r;
  logic          ack1_r;
  logic          err1_r;
  logic [DW-1:0] rdata0_r;
  logic [DW-1:0] rdata1_r;
  logic          busy_r;

  assign req_s = {req1, req0};

  cmam_rr_pick u_pick (
    .req  (req_s),
    .last (last_r),
    .gnt  (gnt_s),
    .sel  (sel_s)
  );

  assign grant_s = |gnt_s;

  // Attributes of the arbitration winner.
  always_comb begin
    win_s = {$bits(cmam_req_t){1'b0}};
    if (sel_s) begin
      win_s.we    = we1;
      win_s.addr  = addr1;
      win_s.wdata = wdata1;
    end else begin
      win_s.we    = we0;
      win_s.addr  = addr0;
      win_s.wdata = wdata0;
    end
  end

  assign prot_s = WRPROT_EN & sel_s & win_s.we & (win_s.addr >= PROT_BASE);

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!grant_s) begin
          state_nxt_s = ST_IDLE;
        end else if (prot_s) begin
          state_nxt_s = ST_ACK;
        end else begin
          state_nxt_s = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (req_r.we) begin
          state_nxt_s = ST_ACK;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 3'd0) begin
          state_nxt_s = ST_ACK;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_ACK:  state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register; busy follows the next state so it rises together with the grant.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != ST_IDLE);
    end
  end

  // Request latch (also the bus address/data register) and round-robin pointer.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      req_r  <= {$bits(cmam_req_t){1'b0}};
      port_r <= 1'b0;
      last_r <= 1'b1;
    end else if ((state_r == ST_IDLE) && grant_s) begin
      port_r <= sel_s;
      if (!prot_s) begin
        req_r <= win_s;
      end
    end else if (state_r == ST_ACK) begin
      last_r <= port_r;
    end
  end

  // Bus strobes (high only while in ISSUE) and read-latency counter.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      wren_r <= 1'b0;
      rden_r <= 1'b0;
      cnt_r  <= 3'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (grant_s && !prot_s) begin
            wren_r <= win_s.we;
            rden_r <= ~win_s.we;
          end else begin
            wren_r <= 1'b0;
            rden_r <= 1'b0;
          end
        end
        ST_ISSUE: begin
          wren_r <= 1'b0;
          rden_r <= 1'b0;
          cnt_r  <= LAT_LOAD;
        end
        ST_WAIT: begin
          if (cnt_r != 3'd0) begin
            cnt_r <= cnt_r - 3'd1;
          end
        end
        default: begin
          wren_r <= 1'b0;
          rden_r <= 1'b0;
        end
      endcase
    end
  end

  // Completion: ack/err pulses and read data, all presented during the ACK state.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      ack0_r   <= 1'b0;
      ack1_r   <= 1'b0;
      err1_r   <= 1'b0;
      rdata0_r <= ZERO_DW;
      rdata1_r <= ZERO_DW;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (grant_s && prot_s) begin
            ack1_r <= 1'b1;
            err1_r <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (req_r.we) begin
            ack0_r <= ~port_r;
            ack1_r <= port_r;
          end
        end
        ST_WAIT: begin
          if (cnt_r == 3'd0) begin
            ack0_r   <= ~port_r;
            ack1_r   <= port_r;
            rdata0_r <= port_r ? ZERO_DW : data_rd;
            rdata1_r <= port_r ? data_rd : ZERO_DW;
          end
        end
        default: begin
          ack0_r   <= 1'b0;
          ack1_r   <= 1'b0;
          err1_r   <= 1'b0;
          rdata0_r <= ZERO_DW;
          rdata1_r <= ZERO_DW;
        end
      endcase
    end
  end

  assign addr    = req_r.addr;
  assign data_wr = req_r.wdata;
  assign wren    = wren_r;
  assign rden    = rden_r;
  assign ack0    = ack0_r;
  assign ack1    = ack1_r;
  assign rdata0  = rdata0_r;
  assign rdata1  = rdata1_r;
  assign err0    = 1'b0;
  assign err1    = err1_r;
  assign busy    = busy_r;

endmodule

// File: tb/tb_cmam_reg_arb.sv
// Bench for cmam_reg_arb: three instances (RD_LAT 2, 1, 7) each with a behavioural register file.
module tb_cmam_reg_arb;
  import cmam_pkg::*;

  localparam int NI = 3;
  localparam int NV = 15;

  logic clk  = 1'b0;
  logic rstb = 1'b1;
  always #5 clk = ~clk;

  logic        req0_a [NI];
  logic        req1_a [NI];
  logic        we0_a  [NI];
  logic        we1_a  [NI];
  logic [6:0]  addr0_a [NI];
  logic [6:0]  addr1_a [NI];
  logic [31:0] wdata0_a [NI];
  logic [31:0] wdata1_a [NI];
  logic        ack0_a [NI];
  logic        ack1_a [NI];
  logic        err0_a [NI];
  logic        err1_a [NI];
  logic [31:0] rdata0_a [NI];
  logic [31:0] rdata1_a [NI];
  logic [6:0]  addr_a [NI];
  logic [31:0] data_wr_a [NI];
  logic        wren_a [NI];
  logic        rden_a [NI];
  logic [31:0] data_rd_a [NI];
  logic        busy_a [NI];

  int tests = 0;
  int fails = 0;
  logic [31:0] ref_mem [NI][128];

  function automatic logic [31:0] init_val(input logic [6:0] a);
    if (a == 7'h10) return 32'h12345678;
    return {8'hA5, 1'b0, a, 16'h0F0F};
  endfunction

  function automatic logic is_prot(input int p, input logic we, input logic [6:0] a);
`ifdef CMAM_ARB_WRPROT_EN
    return (p == 1) && we && (a >= 7'h60);
`else
    return 1'b0;
`endif
  endfunction

  // Register-file model: data_rd is valid only in the cycle exactly LAT cycles after rden.
  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 7);
    logic [31:0] mem [128];
    logic [6:0]  rd_addr = 7'h00;
    int          age = 0;

    initial begin
      for (int a = 0; a < 128; a++) mem[a] <= init_val(7'(a));
    end

    always @(posedge clk) begin
      if (wren_a[g]) mem[addr_a[g]] <= data_wr_a[g];
      if (rden_a[g]) begin
        age     <= 1;
        rd_addr <= addr_a[g];
      end else if (age != 0 && age < 100) begin
        age <= age + 1;
      end
    end

    assign data_rd_a[g] = (age == LAT) ? mem[rd_addr] : (32'hBAD0_0000 | 32'(age));

    cmam_reg_arb #(.RD_LAT(LAT)) u_dut (
      .clk     (clk),
      .rstb    (rstb),
      .req0    (req0_a[g]),
      .we0     (we0_a[g]),
      .addr0   (addr0_a[g]),
      .wdata0  (wdata0_a[g]),
      .ack0    (ack0_a[g]),
      .rdata0  (rdata0_a[g]),
      .err0    (err0_a[g]),
      .req1    (req1_a[g]),
      .we1     (we1_a[g]),
      .addr1   (addr1_a[g]),
      .wdata1  (wdata1_a[g]),
      .ack1    (ack1_a[g]),
      .rdata1  (rdata1_a[g]),
      .err1    (err1_a[g]),
      .addr    (addr_a[g]),
      .data_wr (data_wr_a[g]),
      .wren    (wren_a[g]),
      .rden    (rden_a[g]),
      .data_rd (data_rd_a[g]),
      .busy    (busy_a[g])
    );
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int i, input int p, input logic v, input logic we,
                         input logic [6:0] a, input logic [31:0] d);
    if (p == 0) begin
      req0_a[i] = v; we0_a[i] = we; addr0_a[i] = a; wdata0_a[i] = d;
    end else begin
      req1_a[i] = v; we1_a[i] = we; addr1_a[i] = a; wdata1_a[i] = d;
    end
  endtask

  task automatic check_quiet(input string nm, input int i);
    check({nm, "_ctrl"}, 64'({ack0_a[i], ack1_a[i], err0_a[i], err1_a[i], wren_a[i],
                              rden_a[i], busy_a[i], addr_a[i]}), 64'd0);
    check({nm, "_rdata"}, {rdata0_a[i], rdata1_a[i]}, 64'd0);
    check({nm, "_data_wr"}, 64'(data_wr_a[i]), 64'd0);
  endtask

  task automatic do_reset();
    rstb = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstb = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // One transaction on a single port, recording latency, strobes and busy.
  task automatic run_txn(input int i, input int p, input logic we, input logic [6:0] a,
                         input logic [31:0] d, output logic [31:0] rd, output logic e,
                         output int lat, output int nw, output int nr, output int pcyc,
                         output logic [6:0] pa, output logic [31:0] pd, output int busy_bad);
    rd = 32'h0; e = 1'b0; lat = -1; nw = 0; nr = 0; pcyc = -1;
    pa = 7'h0; pd = 32'h0; busy_bad = 0;
    set_req(i, p, 1'b1, we, a, d);
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if ((wren_a[i] || rden_a[i]) && pcyc < 0) begin
        pcyc = n; pa = addr_a[i]; pd = data_wr_a[i];
      end
      if (wren_a[i]) nw++;
      if (rden_a[i]) nr++;
      if (!busy_a[i]) busy_bad++;
      if ((p == 0) ? ack0_a[i] : ack1_a[i]) begin
        lat = n;
        rd  = (p == 0) ? rdata0_a[i] : rdata1_a[i];
        e   = (p == 0) ? err0_a[i] : err1_a[i];
        break;
      end
    end
    set_req(i, p, 1'b0, we, a, d);
  endtask

  task automatic rand_port(input int p, input int n);
    logic we, e, exp_e;
    logic [6:0] a;
    logic [31:0] d, rd, exp_rd;
    bit got;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      we = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 1) == 1) ? 7'h58 + 7'($urandom_range(0, 15))
                                       : 7'($urandom_range(0, 15));
      d  = $urandom;
      rd = 32'h0; e = 1'b0;
      set_req(0, p, 1'b1, we, a, d);
      got = 1'b0;
      for (int c = 0; c < 40 && !got; c++) begin
        @(posedge clk);
        #1;
        if ((p == 0) ? ack0_a[0] : ack1_a[0]) begin
          got = 1'b1;
          rd  = (p == 0) ? rdata0_a[0] : rdata1_a[0];
          e   = (p == 0) ? err0_a[0] : err1_a[0];
        end
      end
      set_req(0, p, 1'b0, we, a, d);
      check($sformatf("rand_p%0d_%0d_ack", p, k), 64'(got), 64'd1);
      if (got) begin
        exp_e  = is_prot(p, we, a);
        exp_rd = we ? 32'h0 : ref_mem[0][a];
        check($sformatf("rand_p%0d_%0d_resp", p, k), 64'({e, rd}), 64'({exp_e, exp_rd}));
        if (we && !exp_e) ref_mem[0][a] = d;
      end
    end
  endtask

  typedef struct {
    int          inst;
    int          port;
    logic        we;
    logic [6:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
    int          exp_w;
    int          exp_r;
  } vec_t;

  vec_t vecs [NV];

  initial begin
    logic [31:0] rd;
    logic e, pw_err;
    int lat, nw, nr, pcyc, bb, pw_lat, pw_w;
    logic [6:0] pa;
    logic [31:0] pd, rd60;
    int got_q[$];
    int last_ack, gap_bad, seen, ack_during;

    pw_err = is_prot(1, 1'b1, 7'h60);
    pw_lat = pw_err ? 1 : 2;
    pw_w   = pw_err ? 0 : 1;
    rd60   = pw_err ? init_val(7'h60) : 32'hCAFEF00D;
    vecs[0]  = '{0, 0, 1'b1, 7'h05, 32'hDEADBEEF, 32'h0,        1'b0,   2,      1,    0};
    vecs[1]  = '{0, 1, 1'b0, 7'h05, 32'h0,        32'hDEADBEEF, 1'b0,   4,      0,    1};
    vecs[2]  = '{0, 1, 1'b0, 7'h10, 32'h0,        32'h12345678, 1'b0,   4,      0,    1};
    vecs[3]  = '{0, 1, 1'b1, 7'h60, 32'hCAFEF00D, 32'h0,        pw_err, pw_lat, pw_w, 0};
    vecs[4]  = '{0, 0, 1'b0, 7'h60, 32'h0,        rd60,         1'b0,   4,      0,    1};
    vecs[5]  = '{0, 1, 1'b1, 7'h5F, 32'h0BADC0DE, 32'h0,        1'b0,   2,      1,    0};
    vecs[6]  = '{0, 0, 1'b1, 7'h60, 32'h11223344, 32'h0,        1'b0,   2,      1,    0};
    vecs[7]  = '{0, 1, 1'b0, 7'h60, 32'h0,        32'h11223344, 1'b0,   4,      0,    1};
    vecs[8]  = '{0, 1, 1'b0, 7'h5F, 32'h0,        32'h0BADC0DE, 1'b0,   4,      0,    1};
    vecs[9]  = '{1, 0, 1'b1, 7'h33, 32'hA1B2C3D4, 32'h0,        1'b0,   2,      1,    0};
    vecs[10] = '{1, 1, 1'b0, 7'h33, 32'h0,        32'hA1B2C3D4, 1'b0,   3,      0,    1};
    vecs[11] = '{1, 0, 1'b0, 7'h10, 32'h0,        32'h12345678, 1'b0,   3,      0,    1};
    vecs[12] = '{2, 1, 1'b1, 7'h44, 32'h55667788, 32'h0,        1'b0,   2,      1,    0};
    vecs[13] = '{2, 0, 1'b0, 7'h44, 32'h0,        32'h55667788, 1'b0,   9,      0,    1};
    vecs[14] = '{2, 1, 1'b0, 7'h10, 32'h0,        32'h12345678, 1'b0,   9,      0,    1};

    for (int i = 0; i < NI; i++) begin
      set_req(i, 0, 1'b0, 1'b0, 7'h0, 32'h0);
      set_req(i, 1, 1'b0, 1'b0, 7'h0, 32'h0);
      for (int a = 0; a < 128; a++) ref_mem[i][a] = init_val(7'(a));
    end

    #3 rstb = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) check_quiet($sformatf("reset_i%0d", i), i);
    rstb = 1'b1;
    @(posedge clk);
    #1;

    // Single-port transactions from the table.
    for (int v = 0; v < NV; v++) begin
      run_txn(vecs[v].inst, vecs[v].port, vecs[v].we, vecs[v].addr, vecs[v].wdata,
              rd, e, lat, nw, nr, pcyc, pa, pd, bb);
      check($sformatf("v%0d_latency", v), 64'(lat), 64'(vecs[v].exp_lat));
      check($sformatf("v%0d_resp", v), 64'({e, rd}), 64'({vecs[v].exp_err, vecs[v].exp_rd}));
      check($sformatf("v%0d_strobes", v), 64'(nw * 16 + nr), 64'(vecs[v].exp_w * 16 + vecs[v].exp_r));
      check($sformatf("v%0d_busy_low", v), 64'(bb), 64'd0);
      if (vecs[v].exp_w + vecs[v].exp_r > 0) begin
        check($sformatf("v%0d_strobe_cycle", v), 64'(pcyc), 64'd1);
        check($sformatf("v%0d_bus_addr", v), 64'(pa), 64'(vecs[v].addr));
        if (vecs[v].we) check($sformatf("v%0d_bus_data", v), 64'(pd), 64'(vecs[v].wdata));
      end
      @(posedge clk);
      #1;
      check($sformatf("v%0d_post_ack", v),
            64'({ack0_a[vecs[v].inst], ack1_a[vecs[v].inst], busy_a[vecs[v].inst],
                 rdata0_a[vecs[v].inst] | rdata1_a[vecs[v].inst]}), 64'd0);
      if (vecs[v].we && !vecs[v].exp_err) ref_mem[vecs[v].inst][vecs[v].addr] = vecs[v].wdata;
    end

    // Both ports held: grants alternate starting with port 0, one IDLE cycle between them.
    do_reset();
    set_req(0, 0, 1'b1, 1'b1, 7'h20, 32'h0000A0A0);
    set_req(0, 1, 1'b1, 1'b1, 7'h21, 32'h0000B1B1);
    last_ack = -10;
    gap_bad  = 0;
    for (int n = 0; n < 80 && got_q.size() < 6; n++) begin
      @(posedge clk);
      #1;
      if (n == last_ack + 1 && busy_a[0]) gap_bad++;
      if (n == last_ack + 2 && !busy_a[0]) gap_bad++;
      if (ack0_a[0] && ack1_a[0]) begin
        gap_bad++;
      end else if (ack0_a[0]) begin
        got_q.push_back(0);
        last_ack = n;
      end else if (ack1_a[0]) begin
        got_q.push_back(1);
        last_ack = n;
      end
    end
    set_req(0, 0, 1'b0, 1'b1, 7'h20, 32'h0000A0A0);
    set_req(0, 1, 1'b0, 1'b1, 7'h21, 32'h0000B1B1);
    check("rr_count", 64'(got_q.size()), 64'd6);
    for (int k = 0; k < got_q.size(); k++) check($sformatf("rr_order_%0d", k), 64'(got_q[k]), 64'(k % 2));
    check("rr_idle_gap", 64'(gap_bad), 64'd0);
    ref_mem[0][7'h20] = 32'h0000A0A0;
    ref_mem[0][7'h21] = 32'h0000B1B1;
    @(posedge clk);
    #1;

    // Reset during the WAIT state of a port-1 read; the held request completes afterwards.
    set_req(0, 1, 1'b1, 1'b0, 7'h10, 32'h0);
    seen = 0;
    for (int n = 0; n < 20 && seen == 0; n++) begin
      @(posedge clk);
      #1;
      if (rden_a[0]) seen = 1;
    end
    check("rst_rden_seen", 64'(seen), 64'd1);
    @(posedge clk);
    #1;
    check("rst_busy_in_wait", 64'(busy_a[0]), 64'd1);
    #2 rstb = 1'b0;
    #1;
    check_quiet("rst_mid", 0);
    ack_during = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (ack0_a[0] || ack1_a[0]) ack_during++;
    end
    check("rst_no_ack", 64'(ack_during), 64'd0);
    rstb = 1'b1;
    seen = 0;
    rd   = 32'h0;
    for (int n = 0; n < 30 && seen == 0; n++) begin
      @(posedge clk);
      #1;
      if (ack1_a[0]) begin
        seen = 1;
        rd   = rdata1_a[0];
      end
    end
    set_req(0, 1, 1'b0, 1'b0, 7'h10, 32'h0);
    check("rst_retry_ack", 64'(seen), 64'd1);
    check("rst_retry_rdata", 64'(rd), 64'(ref_mem[0][7'h10]));
    @(posedge clk);
    #1;

    // Randomized concurrent traffic on both ports against the reference memory.
    fork
      rand_port(0, 25);
      rand_port(1, 25);
    join

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

endmodule
